noc_input_port: RTL and testbench
=================================

Name: noc_input_port

Overview:
Router input-port front end; this is the requester side of the 5-port round-robin arbiter. It buffers incoming flits from one upstream link in a FIFO and decodes the head-flit destination with YX routing. It then holds a one-hot request to the arbiter for the whole packet, pops one flit per grant and returns one credit upstream per popped flit. One instance sits on each of N, S, W, E and L.

Parameters:
DATA_WIDTH, 32, flit width; [DW-1:DW-2] = type (01 HEAD, 00 BODY, 10 TAIL, 11 SINGLE)
COORD_W, 2, width of each destination coordinate; dest_x = flit[COORD_W-1:0], dest_y = flit[2*COORD_W-1:COORD_W]
DEPTH, 4, FIFO depth in flits, power of two, >= 2
LOCAL_X, 1, this router's X coordinate
LOCAL_Y, 1, this router's Y coordinate

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
flit_in  in  DATA_WIDTH  upstream flit
flit_valid_in  in  1  flit_in valid this cycle
credit_out  out  1  one-cycle pulse per flit popped
req_out  out  5  one-hot request to arbiter, bit order {N,S,W,E,L} = [4:0]
grant_in  in  1  arbiter grant for this port, one flit per cycle asserted
flit_out  out  DATA_WIDTH  registered flit to crossbar
flit_valid_out  out  1  flit_out valid
occupancy  out  $clog2(DEPTH)+1  current FIFO count
err_out  out  1  sticky protocol error

Behaviour:
- Reset (synchronous, active-high): the following clear on the first clk edge with rst=1, from any state including mid-packet:
  - FIFO pointers and occupancy to 0
  - FSM to IDLE
  - req_out to 0, credit_out to 0, flit_out to 0, flit_valid_out to 0, err_out to 0
- Write: flit_valid_in with FIFO not full pushes flit_in. When full, the flit is dropped and err_out sets. The upstream credit scheme makes this illegal, so a drop is an error, not backpressure.
- Simultaneous push and pop while full is legal. The pop frees the slot in the same cycle and occupancy is unchanged.
- FSM IDLE:
  - FIFO front is HEAD or SINGLE: compute route and latch it into route_q; go to ACTIVE next cycle. Route latency is 1 cycle, and req_out is 0 during IDLE.
  - FIFO front is BODY or TAIL: pop it silently with no credit, set err_out, stay IDLE.
  - FIFO empty: stay IDLE.
- YX route, with dest_y and dest_x compared unsigned:
  - dest_y > LOCAL_Y: N
  - dest_y < LOCAL_Y: S
  - else dest_x > LOCAL_X: E
  - else dest_x < LOCAL_X: W
  - else: L
- FSM ACTIVE:
  - req_out = route_q while FIFO not empty; req_out = 0 while empty. The packet lock holds, so route_q is kept.
  - grant_in=1 with req_out non-zero: pop the front flit. On the next cycle flit_out = that flit, flit_valid_out = 1 and credit_out = 1, all registered with 1-cycle latency.
  - If the popped flit is TAIL or SINGLE: go to IDLE. req_out drops to 0 in the following cycle even if the FIFO still holds a new head. The next packet re-routes through IDLE, giving a 1-cycle bubble between packets.
  - HEAD seen at the front while ACTIVE (missing tail): set err_out, forward it anyway, keep route_q.
- grant_in while req_out = 0: ignored, no pop. err_out sets only if the FIFO is empty.
- flit_valid_out and credit_out are 0 in any cycle after which no pop occurred.
- Pointers wrap modulo DEPTH; occupancy ranges 0..DEPTH.
- err_out stays set until rst.

Test Plan:
1. LOCAL=(1,1). Push SINGLE with dest (x=1, y=2) → req_out=5'b10000 two cycles after the push. Grant 1 cycle → flit_out equals the pushed flit, flit_valid_out=1, credit_out=1 pulse, occupancy 0, FSM IDLE.
2. Push HEAD, BODY, TAIL with dest (3,1) → req_out=5'b00010 (E). Grant held 3 cycles → 3 consecutive flit_valid_out and credit_out pulses, in order. req_out=0 after the tail.
3. Routing sweep with dests (1,0)→S 01000, (0,1)→W 00100, (1,1)→L 00001, (0,3)→N 10000 (Y is resolved before X).
4. Fill 4 flits, push a 5th without popping → occupancy stays 4, the 5th flit is absent on output, err_out=1. Also push and grant in the same cycle while full → occupancy stays 4, err_out not newly set.
5. BODY flit arrives with the FSM IDLE → dropped, no credit_out, err_out=1. A following HEAD routes normally.
6. Assert rst mid-packet after the HEAD is granted → next cycle req_out=0, occupancy=0, flit_valid_out=0, err_out=0. A new SINGLE is routed correctly afterwards.

Source files
------------

// File: rtl/noc_input_port_if.sv
// Bundle of the flit, credit, request and status signals between one router
// input port and its neighbours (upstream link, arbiter and crossbar).
interface noc_input_port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  logic [DATA_WIDTH-1:0]    flit_in;
  logic                     flit_valid_in;
  logic                     credit_out;
  logic [4:0]               req_out;
  logic                     grant_in;
  logic [DATA_WIDTH-1:0]    flit_out;
  logic                     flit_valid_out;
  logic [$clog2(DEPTH):0]   occupancy;
  logic                     err_out;

  // Environment side: upstream link, arbiter and crossbar
  modport master (
    output flit_in, flit_valid_in, grant_in,
    input  credit_out, req_out, flit_out, flit_valid_out, occupancy, err_out
  );

  // Input port side
  modport slave (
    input  flit_in, flit_valid_in, grant_in,
    output credit_out, req_out, flit_out, flit_valid_out, occupancy, err_out
  );
endinterface

// File: rtl/noc_input_port.sv
// Router input port: buffers upstream flits, YX-routes each packet head and
// holds a one-hot request to the output arbiter for the whole packet, popping
// one flit per grant and returning one credit per forwarded flit.
module noc_input_port #(
  parameter int DATA_WIDTH = 32,
  parameter int COORD_W    = 2,
  parameter int DEPTH      = 4,
  parameter int LOCAL_X    = 1,
  parameter int LOCAL_Y    = 1
) (
  input logic             clk,
  input logic             rst,
  noc_input_port_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  state_t     state, state_next;
  logic [4:0] route_q, route_next, route_calc, req;
  logic       head_sent, head_sent_next;
  logic       pop, push, fwd, err_set;

  logic [DATA_WIDTH-1:0] front;
  logic [1:0]            front_type;
  logic [COORD_W-1:0]    dest_x, dest_y;
  logic                  empty, full;

  logic [DATA_WIDTH-1:0] flit_q;
  logic                  valid_q, credit_q, err_q;

  assign front      = mem[rd_ptr];
  assign front_type = front[DATA_WIDTH-1:DATA_WIDTH-2];
  assign dest_x     = front[COORD_W-1:0];
  assign dest_y     = front[2*COORD_W-1:COORD_W];
  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));

  // A full FIFO can still accept a flit when the same cycle frees a slot
  assign push = bus.flit_valid_in && (!full || pop);

  // YX routing of the front flit: resolve the Y dimension before X
  always_comb begin
    route_calc = 5'b00001;
    if (dest_y > COORD_W'(LOCAL_Y))      route_calc = 5'b10000;
    else if (dest_y < COORD_W'(LOCAL_Y)) route_calc = 5'b01000;
    else if (dest_x > COORD_W'(LOCAL_X)) route_calc = 5'b00010;
    else if (dest_x < COORD_W'(LOCAL_X)) route_calc = 5'b00100;
  end

  // Packet FSM: route heads in IDLE, stream granted flits in ACTIVE
  always_comb begin
    state_next     = state;
    route_next     = route_q;
    head_sent_next = head_sent;
    req            = 5'b00000;
    pop            = 1'b0;
    fwd            = 1'b0;
    err_set        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (front_type == T_HEAD || front_type == T_SINGLE) begin
            route_next     = route_calc;
            head_sent_next = 1'b0;
            state_next     = ACTIVE;
          end else begin
            pop     = 1'b1;
            err_set = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!empty) begin
          req = route_q;
          if (bus.grant_in) begin
            pop            = 1'b1;
            fwd            = 1'b1;
            head_sent_next = 1'b1;
            if (front_type == T_HEAD && head_sent) err_set = 1'b1;
            if (front_type == T_TAIL || front_type == T_SINGLE) state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (bus.grant_in && empty) err_set = 1'b1;
    if (bus.flit_valid_in && full && !pop) err_set = 1'b1;
  end

  // FSM state, latched route and packet progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      route_q   <= 5'b00000;
      head_sent <= 1'b0;
    end else begin
      state     <= state_next;
      route_q   <= route_next;
      head_sent <= head_sent_next;
    end
  end

  // Flit storage; contents need no reset because the count guards reads
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.flit_in;
  end

  // FIFO pointers and occupancy, wrapping naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Registered crossbar output, credit return and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_q   <= '0;
      valid_q  <= 1'b0;
      credit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (fwd) flit_q <= front;
      valid_q  <= fwd;
      credit_q <= fwd;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.req_out        = req;
  assign bus.occupancy      = count;
  assign bus.flit_out       = flit_q;
  assign bus.flit_valid_out = valid_q;
  assign bus.credit_out     = credit_q;
  assign bus.err_out        = err_q;

endmodule

// File: tb/tb_noc_input_port.sv
// Directed self-checking bench for the router input port (LOCAL = (1,1)).
module tb_noc_input_port;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  noc_input_port_if #(.DATA_WIDTH(32), .DEPTH(4)) bus ();

  noc_input_port #(
    .DATA_WIDTH(32), .COORD_W(2), .DEPTH(4), .LOCAL_X(1), .LOCAL_Y(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Flit builder: {type, zeros, tag, dest_y, dest_x}
  function automatic logic [31:0] mk(input logic [1:0] t, input logic [1:0] x,
                                     input logic [1:0] y, input logic [7:0] tag);
    return {t, 18'd0, tag, y, x};
  endfunction

  // Advance one clock; drive and sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.flit_valid_in = 1'b0;
    bus.grant_in = 1'b0;
    bus.flit_in = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] f);
    bus.flit_in = f;
    bus.flit_valid_in = 1'b1;
    tick();
    bus.flit_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_compared++;
    if ({bus.req_out, bus.occupancy, bus.flit_valid_out, bus.credit_out, bus.err_out, bus.flit_out} !== 42'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state actual=%b/%0d/%b/%b/%b/%h required=all zero",
               bus.req_out, bus.occupancy, bus.flit_valid_out, bus.credit_out, bus.err_out, bus.flit_out);
    end
  endtask

  task automatic test_single();
    logic [31:0] f;
    do_reset();
    f = mk(2'b11, 2'd1, 2'd2, 8'h11);
    push(f);
    n_compared++;
    if (bus.req_out !== 5'b00000) begin
      n_mismatched++; $display("[TB] FAIL single_idle_req actual=%b required=00000", bus.req_out);
    end
    tick();
    n_compared++;
    if (bus.req_out !== 5'b10000) begin
      n_mismatched++; $display("[TB] FAIL single_req actual=%b required=10000", bus.req_out);
    end
    bus.grant_in = 1'b1;
    tick();
    bus.grant_in = 1'b0;
    n_compared++;
    if (bus.flit_out !== f || bus.flit_valid_out !== 1'b1 || bus.credit_out !== 1'b1 || bus.occupancy !== 3'd0) begin
      n_mismatched++;
      $display("[TB] FAIL single_out actual=%h/%b/%b/%0d required=%h/1/1/0",
               bus.flit_out, bus.flit_valid_out, bus.credit_out, bus.occupancy, f);
    end
    tick();
    n_compared++;
    if (bus.req_out !== 5'b00000 || bus.flit_valid_out !== 1'b0 || bus.credit_out !== 1'b0 || bus.err_out !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL single_after actual=%b/%b/%b/%b required=00000/0/0/0",
               bus.req_out, bus.flit_valid_out, bus.credit_out, bus.err_out);
    end
  endtask

  task automatic test_packet();
    logic [31:0] p [3];
    do_reset();
    p[0] = mk(2'b01, 2'd3, 2'd1, 8'h21);
    p[1] = mk(2'b00, 2'd0, 2'd0, 8'h22);
    p[2] = mk(2'b10, 2'd0, 2'd0, 8'h23);
    for (int i = 0; i < 3; i++) push(p[i]);
    n_compared++;
    if (bus.req_out !== 5'b00010 || bus.occupancy !== 3'd3) begin
      n_mismatched++; $display("[TB] FAIL packet_req actual=%b/%0d required=00010/3", bus.req_out, bus.occupancy);
    end
    bus.grant_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) bus.grant_in = 1'b0;
      n_compared++;
      if (bus.flit_out !== p[i] || bus.flit_valid_out !== 1'b1 || bus.credit_out !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL packet_flit%0d actual=%h/%b/%b required=%h/1/1",
                 i, bus.flit_out, bus.flit_valid_out, bus.credit_out, p[i]);
      end
    end
    n_compared++;
    if (bus.req_out !== 5'b00000 || bus.err_out !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL packet_end actual=%b/%b required=00000/0", bus.req_out, bus.err_out);
    end
  endtask

  task automatic test_route_sweep();
    logic [1:0] xs [4];
    logic [1:0] ys [4];
    logic [4:0] exp_req [4];
    logic [31:0] f;
    xs = '{2'd1, 2'd0, 2'd1, 2'd0};
    ys = '{2'd0, 2'd1, 2'd1, 2'd3};
    exp_req = '{5'b01000, 5'b00100, 5'b00001, 5'b10000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      f = mk(2'b11, xs[i], ys[i], 8'(8'h30 + i));
      push(f);
      tick();
      n_compared++;
      if (bus.req_out !== exp_req[i]) begin
        n_mismatched++;
        $display("[TB] FAIL route%0d actual=%b required=%b", i, bus.req_out, exp_req[i]);
      end
      bus.grant_in = 1'b1;
      tick();
      bus.grant_in = 1'b0;
      n_compared++;
      if (bus.flit_out !== f || bus.flit_valid_out !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL route%0d_out actual=%h/%b required=%h/1", i, bus.flit_out, bus.flit_valid_out, f);
      end
      tick();
    end
  endtask

  task automatic test_full();
    logic [31:0] p [5];
    do_reset();
    p[0] = mk(2'b01, 2'd3, 2'd1, 8'h41);
    p[1] = mk(2'b00, 2'd0, 2'd0, 8'h42);
    p[2] = mk(2'b00, 2'd0, 2'd0, 8'h43);
    p[3] = mk(2'b00, 2'd0, 2'd0, 8'h44);
    p[4] = mk(2'b10, 2'd0, 2'd0, 8'h45);
    for (int i = 0; i < 4; i++) push(p[i]);
    n_compared++;
    if (bus.occupancy !== 3'd4 || bus.err_out !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL full_fill actual=%0d/%b required=4/0", bus.occupancy, bus.err_out);
    end
    bus.grant_in = 1'b1;
    push(p[4]);
    bus.grant_in = 1'b0;
    n_compared++;
    if (bus.occupancy !== 3'd4 || bus.err_out !== 1'b0 || bus.flit_out !== p[0] || bus.flit_valid_out !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL full_pushpop actual=%0d/%b/%h/%b required=4/0/%h/1",
               bus.occupancy, bus.err_out, bus.flit_out, bus.flit_valid_out, p[0]);
    end
    push(mk(2'b00, 2'd0, 2'd0, 8'h99));
    n_compared++;
    if (bus.occupancy !== 3'd4 || bus.err_out !== 1'b1 || bus.flit_valid_out !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL full_drop actual=%0d/%b/%b required=4/1/0", bus.occupancy, bus.err_out, bus.flit_valid_out);
    end
    bus.grant_in = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      if (i == 4) bus.grant_in = 1'b0;
      n_compared++;
      if (bus.flit_out !== p[i] || bus.flit_valid_out !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL full_drain%0d actual=%h/%b required=%h/1", i, bus.flit_out, bus.flit_valid_out, p[i]);
      end
    end
    n_compared++;
    if (bus.occupancy !== 3'd0 || bus.req_out !== 5'b00000) begin
      n_mismatched++; $display("[TB] FAIL full_empty actual=%0d/%b required=0/00000", bus.occupancy, bus.req_out);
    end
  endtask

  task automatic test_orphan_body();
    do_reset();
    push(mk(2'b00, 2'd1, 2'd1, 8'h51));
    tick();
    n_compared++;
    if (bus.occupancy !== 3'd0 || bus.err_out !== 1'b1 || bus.credit_out !== 1'b0 || bus.flit_valid_out !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL orphan_drop actual=%0d/%b/%b/%b required=0/1/0/0",
               bus.occupancy, bus.err_out, bus.credit_out, bus.flit_valid_out);
    end
    tick();
    n_compared++;
    if (bus.credit_out !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL orphan_credit actual=%b required=0", bus.credit_out);
    end
    push(mk(2'b01, 2'd1, 2'd1, 8'h52));
    tick();
    n_compared++;
    if (bus.req_out !== 5'b00001) begin
      n_mismatched++; $display("[TB] FAIL orphan_next_req actual=%b required=00001", bus.req_out);
    end
  endtask

  task automatic test_missing_tail();
    logic [31:0] h1, h2, t;
    do_reset();
    h1 = mk(2'b01, 2'd3, 2'd1, 8'h61);
    h2 = mk(2'b01, 2'd0, 2'd3, 8'h62);
    t  = mk(2'b10, 2'd0, 2'd0, 8'h63);
    push(h1);
    push(h2);
    bus.grant_in = 1'b1;
    tick();
    n_compared++;
    if (bus.err_out !== 1'b0 || bus.flit_out !== h1) begin
      n_mismatched++; $display("[TB] FAIL mt_first actual=%b/%h required=0/%h", bus.err_out, bus.flit_out, h1);
    end
    tick();
    bus.grant_in = 1'b0;
    n_compared++;
    if (bus.err_out !== 1'b1 || bus.flit_out !== h2 || bus.flit_valid_out !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL mt_second actual=%b/%h/%b required=1/%h/1", bus.err_out, bus.flit_out, bus.flit_valid_out, h2);
    end
    push(t);
    n_compared++;
    if (bus.req_out !== 5'b00010) begin
      n_mismatched++; $display("[TB] FAIL mt_route_kept actual=%b required=00010", bus.req_out);
    end
    bus.grant_in = 1'b1;
    tick();
    bus.grant_in = 1'b0;
    tick();
    n_compared++;
    if (bus.req_out !== 5'b00000 || bus.occupancy !== 3'd0) begin
      n_mismatched++; $display("[TB] FAIL mt_end actual=%b/%0d required=00000/0", bus.req_out, bus.occupancy);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] h, s;
    do_reset();
    h = mk(2'b01, 2'd3, 2'd1, 8'h71);
    s = mk(2'b11, 2'd0, 2'd3, 8'h72);
    push(h);
    push(mk(2'b00, 2'd0, 2'd0, 8'h73));
    bus.grant_in = 1'b1;
    tick();
    bus.grant_in = 1'b0;
    n_compared++;
    if (bus.flit_valid_out !== 1'b1 || bus.req_out !== 5'b00010) begin
      n_mismatched++; $display("[TB] FAIL mr_pre actual=%b/%b required=1/00010", bus.flit_valid_out, bus.req_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_compared++;
    if ({bus.req_out, bus.occupancy, bus.flit_valid_out, bus.credit_out, bus.err_out, bus.flit_out} !== 42'd0) begin
      n_mismatched++;
      $display("[TB] FAIL mr_cleared actual=%b/%0d/%b/%b/%b/%h required=all zero",
               bus.req_out, bus.occupancy, bus.flit_valid_out, bus.credit_out, bus.err_out, bus.flit_out);
    end
    push(s);
    tick();
    n_compared++;
    if (bus.req_out !== 5'b10000) begin
      n_mismatched++; $display("[TB] FAIL mr_new_req actual=%b required=10000", bus.req_out);
    end
    bus.grant_in = 1'b1;
    tick();
    bus.grant_in = 1'b0;
    n_compared++;
    if (bus.flit_out !== s || bus.credit_out !== 1'b1 || bus.err_out !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL mr_new_out actual=%h/%b/%b required=%h/1/0", bus.flit_out, bus.credit_out, bus.err_out, s);
    end
  endtask

  // Scenario sequence
  initial begin
    bus.flit_in = '0;
    bus.flit_valid_in = 1'b0;
    bus.grant_in = 1'b0;
    #1;
    test_reset();
    test_single();
    test_packet();
    test_route_sweep();
    test_full();
    test_orphan_body();
    test_missing_tail();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
